// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  // Controller state: normal flow, or holding the pipe for a slow dmem access
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  // EX operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Hard-wired zero register; never a forwarding or hazard source
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/fwd_unit.sv
// EX-stage operand forwarding select for one source register.
// The younger result (MEM) wins over the older one (WB); $0 is never forwarded.
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] ex_src,
  input  logic       mem_reg_write,
  input  logic [4:0] mem_rd_dst,
  input  logic       wb_reg_write,
  input  logic [4:0] wb_rd_dst,
  output logic [1:0] fwd_sel
);

  // Pick the most recent in-flight producer of ex_src
  always_comb begin
    fwd_sel = FWD_RF;
    if (mem_reg_write && (mem_rd_dst != REG_ZERO) && (mem_rd_dst == ex_src)) begin
      fwd_sel = FWD_MEM;
    end else if (wb_reg_write && (wb_rd_dst != REG_ZERO) && (wb_rd_dst == ex_src)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage MIPS pipeline.
// Freezes the pipe for multi-cycle dmem accesses (with bounded timeout),
// inserts load-use bubbles, flushes on taken branches and drives EX forwarding.
// Optional build macro PIPE_HAZ_PERF_EN adds saturating performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned WCNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd_dst,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd_dst,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd_dst,
  input  logic        branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mem_wb_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
`ifdef PIPE_HAZ_PERF_EN
  output logic [31:0] stall_cycles,
  output logic [15:0] loaduse_cnt,
  output logic [15:0] flush_cnt,
`endif
  output logic        mem_err
);

  localparam logic [WCNT_W-1:0] WaitLast = WCNT_W'(MAX_WAIT - 1);
  localparam logic [WCNT_W-1:0] WaitOne  = WCNT_W'(1);

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;

  logic       stall_req;
  logic       timeout;
  logic       timeout_hit;
  logic       freeze;
  logic       load_use;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;

  assign stall_req   = dmem_req & ~dmem_ready;
  assign timeout     = (state_q == MEM_WAIT) && (wait_cnt_q == WaitLast);
  assign freeze      = stall_req & ~timeout;
  // Access abandoned on this cycle: release the pipe but never write it back
  assign timeout_hit = stall_req & timeout;
  assign load_use    = ex_mem_read && (ex_rd_dst != REG_ZERO) &&
                       ((ex_rd_dst == id_rs) || (ex_rd_dst == id_rt));

  fwd_unit u_fwd_a (
    .ex_src        (ex_rs),
    .mem_reg_write (mem_reg_write),
    .mem_rd_dst    (mem_rd_dst),
    .wb_reg_write  (wb_reg_write),
    .wb_rd_dst     (wb_rd_dst),
    .fwd_sel       (fwd_a_raw)
  );

  fwd_unit u_fwd_b (
    .ex_src        (ex_rt),
    .mem_reg_write (mem_reg_write),
    .mem_rd_dst    (mem_rd_dst),
    .wb_reg_write  (wb_reg_write),
    .wb_rd_dst     (wb_rd_dst),
    .fwd_sel       (fwd_b_raw)
  );

  // Stage enables/flushes: reset > freeze > branch > load-use > normal
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    fwd_a        = fwd_a_raw;
    fwd_b        = fwd_b_raw;
    if (rst) begin
      // Keep everything loading bubbles so the pipe fills clean
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
      fwd_a        = FWD_RF;
      fwd_b        = FWD_RF;
    end else if (freeze) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else begin
      mem_wb_flush = timeout_hit;
      if (branch_taken) begin
        // ID instruction is discarded, so any load-use hazard is moot
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        // One bubble: the load leaves EX on the next edge
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  // Wait FSM next state: stay in MEM_WAIT only while frozen
  always_comb begin
    state_d    = RUN;
    wait_cnt_d = '0;
    mem_err_d  = mem_err_q | timeout_hit;
    if (freeze) begin
      state_d    = MEM_WAIT;
      wait_cnt_d = (state_q == MEM_WAIT) ? (wait_cnt_q + WaitOne) : '0;
    end
  end

  // FSM, wait counter and sticky error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;

`ifdef PIPE_HAZ_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] loaduse_cnt_q;
  logic [15:0] flush_cnt_q;
  logic        loaduse_evt;
  logic        flush_evt;

  assign loaduse_evt = ~freeze & ~branch_taken & load_use;
  assign flush_evt   = ~freeze & branch_taken;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      loaduse_cnt_q  <= '0;
      flush_cnt_q    <= '0;
    end else begin
      if (freeze && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (loaduse_evt && (loaduse_cnt_q != '1)) loaduse_cnt_q <= loaduse_cnt_q + 16'd1;
      if (flush_evt && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign loaduse_cnt  = loaduse_cnt_q;
  assign flush_cnt    = flush_cnt_q;
`else
  // Performance counters not built
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MW = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd_dst, mem_rd_dst, wb_rd_dst;
  logic       ex_mem_read, mem_reg_write, wb_reg_write, branch_taken, dmem_req, dmem_ready;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic       if_id_flush, id_ex_flush, mem_wb_flush, mem_err;
  logic [1:0] fwd_a, fwd_b;
`ifdef PIPE_HAZ_PERF_EN
  logic [31:0] stall_cycles;
  logic [15:0] loaduse_cnt, flush_cnt;
`endif

  pipe_hazard_ctrl #(.MAX_WAIT(MW), .WCNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .ex_mem_read   (ex_mem_read),
    .ex_rd_dst     (ex_rd_dst),
    .mem_reg_write (mem_reg_write),
    .mem_rd_dst    (mem_rd_dst),
    .wb_reg_write  (wb_reg_write),
    .wb_rd_dst     (wb_rd_dst),
    .branch_taken  (branch_taken),
    .dmem_req      (dmem_req),
    .dmem_ready    (dmem_ready),
    .pc_en         (pc_en),
    .if_id_en      (if_id_en),
    .id_ex_en      (id_ex_en),
    .ex_mem_en     (ex_mem_en),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .mem_wb_flush  (mem_wb_flush),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
`ifdef PIPE_HAZ_PERF_EN
    .stall_cycles  (stall_cycles),
    .loaduse_cnt   (loaduse_cnt),
    .flush_cnt     (flush_cnt),
`endif
    .mem_err       (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt;
    logic       ex_mem_read;
    logic [4:0] ex_rd_dst;
    logic       mem_reg_write;
    logic [4:0] mem_rd_dst;
    logic       wb_reg_write;
    logic [4:0] wb_rd_dst;
    logic       branch_taken, dmem_req, dmem_ready;
  } in_t;

  // {pc, if_id, id_ex, ex_mem enables}, {if_id, id_ex, mem_wb flushes}, fwd_a, fwd_b, mem_err
  typedef struct packed {
    logic [3:0] en;
    logic [2:0] fl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       err;
  } out_t;

  typedef struct {
    string name;
    in_t   in;
    out_t  exp;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Reference model state: consecutive frozen cycles of the current access, sticky error
  int   consec;
  bit   m_err;
  longint m_stall, m_lu, m_fl;

  function automatic in_t mk_in(logic r, logic [4:0] irs, logic [4:0] irt, logic [4:0] ers,
                                logic [4:0] ert, logic ld, logic [4:0] exd, logic mw,
                                logic [4:0] md, logic ww, logic [4:0] wd, logic br,
                                logic req, logic rdy);
    return {r, irs, irt, ers, ert, ld, exd, mw, md, ww, wd, br, req, rdy};
  endfunction

  function automatic out_t mk(logic [3:0] en, logic [2:0] fl, logic [1:0] fa, logic [1:0] fb,
                              logic err);
    return {en, fl, fa, fb, err};
  endfunction

  task automatic add(string n, in_t i, out_t e);
    vec_t v;
    v.name = n;
    v.in   = i;
    v.exp  = e;
    vq.push_back(v);
  endtask

  task automatic drive(in_t i);
    rst           = i.rst;
    id_rs         = i.id_rs;
    id_rt         = i.id_rt;
    ex_rs         = i.ex_rs;
    ex_rt         = i.ex_rt;
    ex_mem_read   = i.ex_mem_read;
    ex_rd_dst     = i.ex_rd_dst;
    mem_reg_write = i.mem_reg_write;
    mem_rd_dst    = i.mem_rd_dst;
    wb_reg_write  = i.wb_reg_write;
    wb_rd_dst     = i.wb_rd_dst;
    branch_taken  = i.branch_taken;
    dmem_req      = i.dmem_req;
    dmem_ready    = i.dmem_ready;
  endtask

  task automatic check(string n, out_t e);
    out_t a;
    a = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_flush,
         fwd_a, fwd_b, mem_err};
    n_checks++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got en=%b fl=%b fa=%b fb=%b err=%b, want en=%b fl=%b fa=%b fb=%b err=%b",
               n, a.en, a.fl, a.fa, a.fb, a.err, e.en, e.fl, e.fa, e.fb, e.err);
    end
  endtask

  // One cycle: apply inputs after the falling edge, sample 1 ns later
  task automatic step(string n, in_t i, out_t e);
    @(negedge clk);
    drive(i);
    #1;
    check(n, e);
  endtask

  function automatic logic [1:0] m_fwd(logic [4:0] src, in_t i);
    if (i.mem_reg_write && i.mem_rd_dst != 0 && i.mem_rd_dst == src) return 2'b10;
    if (i.wb_reg_write && i.wb_rd_dst != 0 && i.wb_rd_dst == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_loaduse(in_t i);
    return i.ex_mem_read && i.ex_rd_dst != 0 &&
           (i.ex_rd_dst == i.id_rs || i.ex_rd_dst == i.id_rt);
  endfunction

  // Access has been held MW full cycles already -> give up on it this cycle
  function automatic bit m_freeze(in_t i);
    return i.dmem_req && !i.dmem_ready && (consec < MW);
  endfunction

  function automatic out_t model_out(in_t i);
    out_t o;
    o.err = m_err;
    if (i.rst) begin
      o.en = 4'b1111; o.fl = 3'b111; o.fa = 2'b00; o.fb = 2'b00;
      return o;
    end
    o.fa = m_fwd(i.ex_rs, i);
    o.fb = m_fwd(i.ex_rt, i);
    if (m_freeze(i)) begin
      o.en = 4'b0000; o.fl = 3'b001;
    end else begin
      o.fl[0] = i.dmem_req && !i.dmem_ready;
      if (i.branch_taken) begin
        o.en = 4'b1111; o.fl[2:1] = 2'b11;
      end else if (m_loaduse(i)) begin
        o.en = 4'b0011; o.fl[2:1] = 2'b01;
      end else begin
        o.en = 4'b1111; o.fl[2:1] = 2'b00;
      end
    end
    return o;
  endfunction

  task automatic model_step(in_t i);
    bit fz;
    fz = m_freeze(i);
    if (i.rst) begin
      consec = 0; m_err = 0; m_stall = 0; m_lu = 0; m_fl = 0;
    end else begin
      if (i.dmem_req && !i.dmem_ready && !fz) m_err = 1;
      if (fz) m_stall = (m_stall < 64'hFFFF_FFFF) ? m_stall + 1 : m_stall;
      if (!fz && !i.branch_taken && m_loaduse(i)) m_lu = (m_lu < 65535) ? m_lu + 1 : m_lu;
      if (!fz && i.branch_taken) m_fl = (m_fl < 65535) ? m_fl + 1 : m_fl;
      consec = fz ? consec + 1 : 0;
    end
  endtask

  initial begin
    in_t  idle, stl, rdy, ri;
    out_t nrm, frz, frz_e;

    nrm   = mk(4'b1111, 3'b000, 2'b00, 2'b00, 1'b0);
    frz   = mk(4'b0000, 3'b001, 2'b00, 2'b00, 1'b0);
    frz_e = mk(4'b0000, 3'b001, 2'b00, 2'b00, 1'b1);
    idle  = mk_in(0, 1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    stl   = mk_in(0, 1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    rdy   = mk_in(0, 1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 1, 1);

    add("normal",      idle, nrm);
    add("lu_rs",       mk_in(0, 8, 2, 3, 4, 1, 8, 0, 0, 0, 0, 0, 0, 0), mk(4'b0011, 3'b010, 0, 0, 0));
    add("lu_rt",       mk_in(0, 1, 8, 3, 4, 1, 8, 0, 0, 0, 0, 0, 0, 0), mk(4'b0011, 3'b010, 0, 0, 0));
    add("lu_zero",     mk_in(0, 0, 0, 3, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0), nrm);
    add("lu_nomatch",  mk_in(0, 9, 10, 3, 4, 1, 8, 0, 0, 0, 0, 0, 0, 0), nrm);
    add("no_load",     mk_in(0, 8, 8, 3, 4, 0, 8, 0, 0, 0, 0, 0, 0, 0), nrm);
    add("fwd_mem_pri", mk_in(0, 1, 2, 5, 0, 0, 0, 1, 5, 1, 5, 0, 0, 0), mk(4'hF, 3'b000, 2'b10, 2'b00, 0));
    add("fwd_wb",      mk_in(0, 1, 2, 5, 0, 0, 0, 0, 5, 1, 5, 0, 0, 0), mk(4'hF, 3'b000, 2'b01, 2'b00, 0));
    add("fwd_b_wb",    mk_in(0, 1, 2, 3, 7, 0, 0, 0, 0, 1, 7, 0, 0, 0), mk(4'hF, 3'b000, 2'b00, 2'b01, 0));
    add("fwd_zero",    mk_in(0, 1, 2, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0), nrm);
    add("fwd_both",    mk_in(0, 1, 2, 6, 6, 0, 0, 1, 6, 1, 6, 0, 0, 0), mk(4'hF, 3'b000, 2'b10, 2'b10, 0));
    add("br_lu",       mk_in(0, 8, 2, 3, 4, 1, 8, 0, 0, 0, 0, 1, 0, 0), mk(4'hF, 3'b110, 0, 0, 0));
    add("br_lu_frz",   mk_in(0, 8, 2, 5, 4, 1, 8, 1, 5, 0, 0, 1, 1, 0), mk(4'h0, 3'b001, 2'b10, 0, 0));
    add("rdy_noreq",   mk_in(0, 1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1), nrm);
    add("rst_out",     mk_in(1, 8, 2, 5, 4, 1, 8, 1, 5, 0, 0, 1, 1, 0), mk(4'hF, 3'b111, 0, 0, 0));
    add("req_rdy",     rdy, nrm);

    drive(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);

    foreach (vq[k]) step(vq[k].name, vq[k].in, vq[k].exp);

    // Load-use bubble lasts exactly one cycle
    step("lu_bubble", mk_in(0, 8, 2, 3, 4, 1, 8, 0, 0, 0, 0, 0, 0, 0), mk(4'b0011, 3'b010, 0, 0, 0));
    step("lu_after",  mk_in(0, 8, 2, 3, 4, 0, 0, 0, 0, 1, 8, 0, 0, 0), nrm);

    // Three wait cycles then ready: released on the 4th, no error
    for (int k = 0; k < 3; k++) step("wait3_frz", stl, frz);
    step("wait3_rel", rdy, nrm);
    step("wait3_idle", idle, nrm);

    // Never ready: MW frozen cycles, then released with a flushed write-back
    for (int k = 0; k < MW; k++) step("to_frz", stl, frz);
    step("to_rel", stl, mk(4'hF, 3'b001, 0, 0, 0));
    for (int k = 0; k < 3; k++) step("to_sticky", idle, mk(4'hF, 3'b000, 0, 0, 1));

    // Reset mid-wait clears the error and restarts the wait count
    step("rw_frz", stl, frz_e);
    step("rw_frz", stl, frz_e);
    step("rw_rst", mk_in(1, 1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0), mk(4'hF, 3'b111, 0, 0, 1));
    for (int k = 0; k < MW; k++) step("rw_refrz", stl, frz);
    step("rw_rel", stl, mk(4'hF, 3'b001, 0, 0, 0));
    step("rw_err", idle, mk(4'hF, 3'b000, 0, 0, 1));

    // Randomized traffic against the model, starting from a clean reset
    step("rand_rst", mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk(4'hF, 3'b111, 0, 0, 1));
    consec = 0; m_err = 0; m_stall = 0; m_lu = 0; m_fl = 0;
    for (int c = 0; c < 3000; c++) begin
      ri.rst           = ($urandom_range(0, 63) == 0);
      ri.id_rs         = 5'($urandom_range(0, 3));
      ri.id_rt         = 5'($urandom_range(0, 3));
      ri.ex_rs         = 5'($urandom_range(0, 3));
      ri.ex_rt         = 5'($urandom_range(0, 3));
      ri.ex_mem_read   = 1'($urandom_range(0, 1));
      ri.ex_rd_dst     = 5'($urandom_range(0, 3));
      ri.mem_reg_write = 1'($urandom_range(0, 1));
      ri.mem_rd_dst    = 5'($urandom_range(0, 3));
      ri.wb_reg_write  = 1'($urandom_range(0, 1));
      ri.wb_rd_dst     = 5'($urandom_range(0, 3));
      ri.branch_taken  = ($urandom_range(0, 4) == 0);
      ri.dmem_req      = ($urandom_range(0, 7) < 5);
      ri.dmem_ready    = ($urandom_range(0, 3) == 0);
      step("rand", ri, model_out(ri));
`ifdef PIPE_HAZ_PERF_EN
      n_checks++;
      if (stall_cycles !== 32'(m_stall) || loaduse_cnt !== 16'(m_lu) || flush_cnt !== 16'(m_fl)) begin
        n_err++;
        $display("FAIL perf: got %0d/%0d/%0d want %0d/%0d/%0d", stall_cycles, loaduse_cnt,
                 flush_cnt, m_stall, m_lu, m_fl);
      end
`endif
      model_step(ri);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
